// File: rtl/elevator_ctrl_scan.sv
// Single-car LOOK-scheduled elevator controller: latches car/hall calls, times travel and
// door dwell with counters, honours door buttons and an emergency freeze.
module elevator_ctrl_scan #(
  parameter int unsigned NUM_FLOORS    = 8,
  parameter int unsigned TRAVEL_CYCLES = 16,
  parameter int unsigned DOOR_CYCLES   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_FLOORS-1:0]         car_req,
  input  logic [NUM_FLOORS-1:0]         hall_up,
  input  logic [NUM_FLOORS-1:0]         hall_down,
  input  logic                          door_open_btn,
  input  logic                          door_close_btn,
  input  logic                          estop,
  output logic [$clog2(NUM_FLOORS)-1:0] cur_floor,
  output logic                          dir,
  output logic                          move,
  output logic                          door_open,
  output logic [NUM_FLOORS-1:0]         pending
);

  localparam int unsigned N  = NUM_FLOORS;
  localparam int unsigned FW = $clog2(NUM_FLOORS);
  localparam int unsigned TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int unsigned DW = $clog2(DOOR_CYCLES + 1);

  localparam logic [TW-1:0] TRV_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DWL_LAST = DW'(DOOR_CYCLES - 1);
  localparam logic [N-1:0]  UP_MASK  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  DN_MASK  = {{(N-1){1'b1}}, 1'b0};
  localparam logic [N-1:0]  ONE_N    = N'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [FW-1:0]   floor_nxt;
  logic            dir_nxt;
  logic [TW-1:0]   trv_cnt, trv_nxt;
  logic [DW-1:0]   dwl_cnt, dwl_nxt;
  logic [N-1:0]    req_car, req_up, req_dn;
  logic [N-1:0]    req_car_nxt, req_up_nxt, req_dn_nxt;
  logic [N-1:0]    clr_car, clr_up, clr_dn;
  logic            move_nxt, door_nxt;
  logic [N-1:0]    pending_nxt;

  logic [N-1:0]    all_req;
  logic [FW-1:0]   arr_floor;
  logic [N-1:0]    cur_oh, arr_oh, ent_oh;
  logic            cur_above, cur_below, arr_above, arr_below;
  logic            beyond_cur, opp_cur, beyond_arr, ent_beyond;
  logic            at_end_arr, arr_stop, go_up, do_entry;
  logic            hit_car, hit_hall;

  // Requests strictly above / below floor f, via one-hot derived masks.
  function automatic logic any_above(input logic [N-1:0] r, input logic [N-1:0] oh);
    any_above = |(r & ~((oh << 1) - ONE_N));
  endfunction

  function automatic logic any_below(input logic [N-1:0] r, input logic [N-1:0] oh);
    any_below = |(r & (oh - ONE_N));
  endfunction

  assign all_req    = req_car | req_up | req_dn;
  assign arr_floor  = dir ? (cur_floor + FW'(1)) : (cur_floor - FW'(1));
  assign cur_oh     = ONE_N << cur_floor;
  assign arr_oh     = ONE_N << arr_floor;
  assign cur_above  = any_above(all_req, cur_oh);
  assign cur_below  = any_below(all_req, cur_oh);
  assign arr_above  = any_above(all_req, arr_oh);
  assign arr_below  = any_below(all_req, arr_oh);
  assign beyond_cur = dir ? cur_above : cur_below;
  assign opp_cur    = dir ? cur_below : cur_above;
  assign beyond_arr = dir ? arr_above : arr_below;
  assign at_end_arr = dir ? (arr_floor == FW'(N - 1)) : (arr_floor == '0);
  assign arr_stop   = req_car[arr_floor] | (dir ? req_up[arr_floor] : req_dn[arr_floor])
                    | ~beyond_arr | at_end_arr;
  assign hit_car    = req_car[cur_floor];
  assign hit_hall   = dir ? req_up[cur_floor] : req_dn[cur_floor];
  assign ent_oh     = (state == MOVE) ? arr_oh : cur_oh;
  assign ent_beyond = (state == MOVE) ? beyond_arr : beyond_cur;

  // Nearest request from idle; equal distance resolves upward.
  always_comb begin : nearest
    int fi;
    int up_d;
    int dn_d;
    fi   = int'(cur_floor);
    up_d = int'(N);
    dn_d = int'(N);
    for (int i = 0; i < int'(N); i++) begin
      if (all_req[i] && (i > fi) && (up_d == int'(N))) up_d = i - fi;
      if (all_req[i] && (i < fi)) dn_d = fi - i;
    end
    go_up = (up_d <= dn_d);
  end

  // State register plus the datapath that moves with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_floor <= '0;
      dir       <= 1'b1;
      trv_cnt   <= '0;
      dwl_cnt   <= '0;
      req_car   <= '0;
      req_up    <= '0;
      req_dn    <= '0;
      move      <= 1'b0;
      door_open <= 1'b0;
      pending   <= '0;
    end else begin
      state     <= state_nxt;
      cur_floor <= floor_nxt;
      dir       <= dir_nxt;
      trv_cnt   <= trv_nxt;
      dwl_cnt   <= dwl_nxt;
      req_car   <= req_car_nxt;
      req_up    <= req_up_nxt;
      req_dn    <= req_dn_nxt;
      move      <= move_nxt;
      door_open <= door_nxt;
      pending   <= pending_nxt;
    end
  end

  // Next state; estop freezes everything except request latching.
  always_comb begin
    state_nxt = state;
    floor_nxt = cur_floor;
    dir_nxt   = dir;
    trv_nxt   = trv_cnt;
    dwl_nxt   = dwl_cnt;
    clr_car   = '0;
    clr_up    = '0;
    clr_dn    = '0;
    do_entry  = 1'b0;
    if (!estop) begin
      case (state)
        IDLE: begin
          if (|all_req) begin
            if (all_req[cur_floor]) begin
              do_entry = 1'b1;
            end else begin
              dir_nxt   = go_up;
              state_nxt = MOVE;
              trv_nxt   = '0;
            end
          end
        end
        MOVE: begin
          if (trv_cnt == TRV_LAST) begin
            trv_nxt   = '0;
            floor_nxt = arr_floor;
            do_entry  = arr_stop;
          end else begin
            trv_nxt = trv_cnt + TW'(1);
          end
        end
        DOOR: begin
          if (door_open_btn || hit_car || hit_hall) begin
            dwl_nxt = '0;
            if (hit_car) clr_car = cur_oh;
            if (hit_hall && dir) clr_up = cur_oh;
            if (hit_hall && !dir) clr_dn = cur_oh;
          end else if (dwl_cnt == DWL_LAST) begin
            dwl_nxt = '0;
            trv_nxt = '0;
            if (beyond_cur) begin
              state_nxt = MOVE;
            end else if (opp_cur) begin
              dir_nxt   = ~dir;
              state_nxt = MOVE;
            end else begin
              state_nxt = IDLE;
            end
          end else if (door_close_btn) begin
            dwl_nxt = DWL_LAST;
          end else begin
            dwl_nxt = dwl_cnt + DW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    // Door entry: serve the floor in the travel direction, turn around if nothing lies ahead.
    if (do_entry) begin
      state_nxt = DOOR;
      dwl_nxt   = '0;
      trv_nxt   = '0;
      clr_car   = ent_oh;
      clr_up    = (dir || !ent_beyond) ? ent_oh : '0;
      clr_dn    = (!dir || !ent_beyond) ? ent_oh : '0;
      if (!ent_beyond) dir_nxt = ~dir;
    end
    req_car_nxt = (req_car & ~clr_car) | car_req;
    req_up_nxt  = (req_up & ~clr_up) | (hall_up & UP_MASK);
    req_dn_nxt  = (req_dn & ~clr_dn) | (hall_down & DN_MASK);
  end

  // Output values registered alongside the state.
  always_comb begin
    move_nxt    = 1'b0;
    door_nxt    = door_open;
    pending_nxt = req_car_nxt | req_up_nxt | req_dn_nxt;
    if (!estop) begin
      move_nxt = (state_nxt == MOVE);
      door_nxt = (state_nxt == DOOR);
    end
  end

endmodule

// File: tb/tb_elevator_ctrl_scan.sv
// Directed bench for elevator_ctrl_scan (8 floors, 4-cycle travel, 6-cycle dwell).
module tb_elevator_ctrl_scan;

  logic       clk;
  logic       rst;
  logic [7:0] car_req, hall_up, hall_down;
  logic       door_open_btn, door_close_btn, estop;
  logic [2:0] cur_floor;
  logic       dir, move, door_open;
  logic [7:0] pending;

  int vectors = 0;
  int errors  = 0;

  elevator_ctrl_scan #(
    .NUM_FLOORS   (8),
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .car_req       (car_req),
    .hall_up       (hall_up),
    .hall_down     (hall_down),
    .door_open_btn (door_open_btn),
    .door_close_btn(door_close_btn),
    .estop         (estop),
    .cur_floor     (cur_floor),
    .dir           (dir),
    .move          (move),
    .door_open     (door_open),
    .pending       (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] car;
    logic [7:0] hup;
    logic [7:0] hdn;
    int         n;
    logic [2:0] floor;
    logic       dr;
    logic       mv;
    logic       door;
    logic [7:0] pend;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input logic r, input logic [7:0] c, input logic [7:0] u,
                              input logic [7:0] d, input int n, input logic [2:0] f,
                              input logic dr, input logic mv, input logic door,
                              input logic [7:0] p);
    vec_t v;
    v.rst = r; v.car = c; v.hup = u; v.hdn = d; v.n = n;
    v.floor = f; v.dr = dr; v.mv = mv; v.door = door; v.pend = p;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [2:0] f, input logic d,
                       input logic m, input logic o, input logic [7:0] p);
    vectors++;
    if (cur_floor !== f || dir !== d || move !== m || door_open !== o || pending !== p) begin
      errors++;
      $display("FAIL %s: got floor=%0d dir=%b move=%b door=%b pending=%h, want floor=%0d dir=%b move=%b door=%b pending=%h",
               name, cur_floor, dir, move, door_open, pending, f, d, m, o, p);
    end
  endtask

  task automatic pulse_car(input logic [7:0] c);
    car_req = c;
    tick(1);
    car_req = '0;
  endtask

  initial begin
    rst = 1'b1; car_req = '0; hall_up = '0; hall_down = '0;
    door_open_btn = 1'b0; door_close_btn = 1'b0; estop = 1'b0;

    // Reset, single car call to floor 3, masked end-floor hall bits.
    vecs[0] = mk(1'b1, 8'h00, 8'h00, 8'h00, 2, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    vecs[1] = mk(1'b0, 8'h08, 8'h00, 8'h00, 1, 3'd0, 1'b1, 1'b0, 1'b0, 8'h08);
    vecs[2] = mk(1'b0, 8'h00, 8'h00, 8'h00, 4, 3'd0, 1'b1, 1'b1, 1'b0, 8'h08);
    vecs[3] = mk(1'b0, 8'h00, 8'h00, 8'h00, 4, 3'd1, 1'b1, 1'b1, 1'b0, 8'h08);
    vecs[4] = mk(1'b0, 8'h00, 8'h00, 8'h00, 4, 3'd2, 1'b1, 1'b1, 1'b0, 8'h08);
    vecs[5] = mk(1'b0, 8'h00, 8'h00, 8'h00, 6, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00);
    vecs[6] = mk(1'b0, 8'h00, 8'h00, 8'h00, 2, 3'd3, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[7] = mk(1'b0, 8'h00, 8'h80, 8'h01, 2, 3'd3, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[8] = mk(1'b0, 8'h00, 8'h00, 8'h00, 1, 3'd3, 1'b0, 1'b0, 1'b0, 8'h00);

    for (int v = 0; v < 9; v++) begin
      rst = vecs[v].rst; car_req = vecs[v].car;
      hall_up = vecs[v].hup; hall_down = vecs[v].hdn;
      for (int c = 0; c < vecs[v].n; c++) begin
        tick(1);
        if (c == 0) begin
          car_req = '0; hall_up = '0; hall_down = '0;
        end
        check($sformatf("vec%0d.%0d", v, c), vecs[v].floor, vecs[v].dr, vecs[v].mv,
              vecs[v].door, vecs[v].pend);
      end
    end

    // Hall calls along the way: stop at 2, pass 4 (down call), stop at 6, return to 4.
    rst = 1'b1; tick(1); rst = 1'b0;
    check("t2_reset", 3'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    car_req = 8'h40; hall_up = 8'h04; hall_down = 8'h10;
    tick(1);
    car_req = '0; hall_up = '0; hall_down = '0;
    tick(1);  check("t2_depart",  3'd0, 1'b1, 1'b1, 1'b0, 8'h54);
    tick(8);  check("t2_stop2",   3'd2, 1'b1, 1'b0, 1'b1, 8'h50);
    tick(6);  check("t2_leave2",  3'd2, 1'b1, 1'b1, 1'b0, 8'h50);
    tick(8);  check("t2_pass4",   3'd4, 1'b1, 1'b1, 1'b0, 8'h50);
    tick(8);  check("t2_stop6",   3'd6, 1'b0, 1'b0, 1'b1, 8'h10);
    tick(6);  check("t2_leave6",  3'd6, 1'b0, 1'b1, 1'b0, 8'h10);
    tick(8);  check("t2_stop4",   3'd4, 1'b1, 1'b0, 1'b1, 8'h00);
    tick(6);  check("t2_idle4",   3'd4, 1'b1, 1'b0, 1'b0, 8'h00);

    // Equal-distance tie from floor 4: up first to 7, then down to 1.
    pulse_car(8'h82);
    tick(1);  check("t3_tie_up",  3'd4, 1'b1, 1'b1, 1'b0, 8'h82);
    tick(12); check("t3_stop7",   3'd7, 1'b0, 1'b0, 1'b1, 8'h02);
    tick(6);  check("t3_leave7",  3'd7, 1'b0, 1'b1, 1'b0, 8'h02);
    tick(24); check("t3_stop1",   3'd1, 1'b1, 1'b0, 1'b1, 8'h00);
    tick(6);  check("t3_idle1",   3'd1, 1'b1, 1'b0, 1'b0, 8'h00);

    // Door buttons at floor 2.
    pulse_car(8'h04);
    tick(5);  check("t4_arrive",  3'd2, 1'b0, 1'b0, 1'b1, 8'h00);
    tick(4);  check("t4_dwell4",  3'd2, 1'b0, 1'b0, 1'b1, 8'h00);
    door_open_btn = 1'b1; tick(1); door_open_btn = 1'b0;
    check("t4_open_press", 3'd2, 1'b0, 1'b0, 1'b1, 8'h00);
    tick(1);  check("t4_extended", 3'd2, 1'b0, 1'b0, 1'b1, 8'h00);
    tick(4);  check("t4_ext_end",  3'd2, 1'b0, 1'b0, 1'b1, 8'h00);
    tick(1);  check("t4_ext_close", 3'd2, 1'b0, 1'b0, 1'b0, 8'h00);
    pulse_car(8'h04);
    tick(1);  check("t4_reopen",   3'd2, 1'b1, 1'b0, 1'b1, 8'h00);
    tick(1);
    door_close_btn = 1'b1; tick(1); door_close_btn = 1'b0;
    check("t4_close_press", 3'd2, 1'b1, 1'b0, 1'b1, 8'h00);
    tick(1);  check("t4_close_done", 3'd2, 1'b1, 1'b0, 1'b0, 8'h00);
    pulse_car(8'h04);
    tick(1);  check("t4_both_open",  3'd2, 1'b0, 1'b0, 1'b1, 8'h00);
    tick(1);
    door_open_btn = 1'b1; door_close_btn = 1'b1; tick(1);
    door_open_btn = 1'b0; door_close_btn = 1'b0;
    tick(1);  check("t4_both_hold",  3'd2, 1'b0, 1'b0, 1'b1, 8'h00);
    tick(4);  check("t4_both_end",   3'd2, 1'b0, 1'b0, 1'b1, 8'h00);
    tick(1);  check("t4_both_close", 3'd2, 1'b0, 1'b0, 1'b0, 8'h00);

    // Emergency freeze between floors 2 and 3, with a call latched while frozen.
    pulse_car(8'h08);
    tick(1);  check("t5_depart",  3'd2, 1'b1, 1'b1, 1'b0, 8'h08);
    tick(2);
    estop = 1'b1;
    tick(1);  check("t5_frozen",  3'd2, 1'b1, 1'b0, 1'b0, 8'h08);
    pulse_car(8'h80);
    check("t5_latch_in_estop", 3'd2, 1'b1, 1'b0, 1'b0, 8'h88);
    tick(8);  check("t5_still_frozen", 3'd2, 1'b1, 1'b0, 1'b0, 8'h88);
    estop = 1'b0;
    tick(1);  check("t5_resume",  3'd2, 1'b1, 1'b1, 1'b0, 8'h88);
    tick(1);  check("t5_arrive3", 3'd3, 1'b1, 1'b0, 1'b1, 8'h80);
    tick(6);  check("t5_leave3",  3'd3, 1'b1, 1'b1, 1'b0, 8'h80);
    tick(8);  check("t5_pass5",   3'd5, 1'b1, 1'b1, 1'b0, 8'h80);

    // Reset while moving drops everything; end-floor hall bits never latch.
    rst = 1'b1;
    tick(1);  check("t6_rst",     3'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    rst = 1'b0; hall_up = 8'h80; hall_down = 8'h01;
    tick(2);  check("t6_masked",  3'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    hall_up = '0; hall_down = '0;
    tick(2);  check("t6_idle",    3'd0, 1'b1, 1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
